ysyx_23060077_lsu_resp: RTL and testbench
=========================================

# ysyx_23060077_lsu_resp

Memory-side responder for the LSU simple load/store bus. It accepts one read or write request at a time from the LSU initiator and services it from an internal word-addressed SRAM after a programmable access latency. It returns right-justified read data with a per-beat `ready` and a final `last`. It sits between the LSU and on-chip RAM and acts as a fast simulation and bring-up memory in place of the AXI crossbar.

## Interface
Parameters:
- `MEM_WORDS`, 1024: SRAM depth in 32-bit words; power of two.
- `ADDR_BASE`, 32'h8000_0000: byte address of word 0.
- `LATENCY`, 2: idle cycles between request accept and first data beat; legal range 0..15.

Ports (reset `reset`, synchronous, active-high; clock `clk`):
- `clk` in 1: clock.
- `reset` in 1: synchronous active-high reset.
- `r_valid_i` in 1: read request; held high until `r_ready_o & r_last_o`.
- `r_addr_i` in 32: read byte address.
- `r_size_i` in 3: 0=byte, 1=half, 2=word.
- `r_len_i` in 8: beats minus one.
- `r_ready_o` out 1: read beat valid, one cycle per beat.
- `r_data_o` out 32: read data, right-justified, upper bits zero.
- `r_last_o` out 1: final read beat.
- `w_valid_i` in 1: write request; held until `w_ready_o & w_last_o`.
- `w_addr_i` in 32: write byte address.
- `w_data_i` in 32: write data, right-justified.
- `w_size_i` in 3: as `r_size_i`.
- `w_len_i` in 8: beats minus one.
- `w_ready_o` out 1: write beat accepted, one cycle per beat.
- `w_last_o` out 1: final write beat.
- `busy_o` out 1: transaction in flight (state != IDLE).

## Operation
- FSM states: IDLE, RWAIT, RBEAT, WWAIT, WBEAT.
- IDLE: if `r_valid_i`, capture addr/size/len and go to RWAIT. Otherwise, if `w_valid_i`, capture addr/size/len and go to WWAIT. Read wins when both are high; the write stays pending.
- WAIT states: a 4-bit counter loads `LATENCY` on accept and decrements. At 0 the FSM moves to its BEAT state. With `LATENCY`=0, the next cycle is already BEAT.
- RBEAT: assert `r_ready_o` for one cycle. `r_data_o` = SRAM word >> (8*addr[1:0]), masked to the size width.
- RBEAT with beats remaining: address += 4 (word-incrementing, offset kept), beat counter decrements, return to RWAIT with the counter reloaded.
- RBEAT on the final beat: assert `r_last_o` alongside `r_ready_o`, then go to IDLE.
- WBEAT: assert `w_ready_o` and sample `w_data_i` that cycle. Byte enables come from size and addr[1:0]; data is shifted left by 8*addr[1:0].
- WBEAT last beat: assert `w_last_o`, then go to IDLE. Otherwise continue as in the read case.
- Out of range: word index = (addr-ADDR_BASE)>>2; out of range when ≥ `MEM_WORDS` or addr < `ADDR_BASE`. Out-of-range reads return 0. Out-of-range writes are dropped. The handshake completes normally in both cases.
- Lane overflow: lanes past byte 3 (e.g. half at offset 3) are truncated, never wrapped.
- Request fields are sampled only at accept. Later changes on addr/data (except per-beat `w_data_i`) are ignored.

## Timing
- Reset values: all outputs 0; FSM IDLE; counters 0. SRAM contents are not reset.
- Reset mid-transaction aborts it. No `ready`/`last` is issued afterwards, and partial writes already committed remain.
- Single-beat latency: accept edge, plus LATENCY WAIT cycles, plus 1 BEAT cycle. With LATENCY=2, a valid seen at edge N gives ready at cycle N+3.
- A new request may be accepted in the cycle after `last`, giving back-to-back operation. The initiator drops valid on the `last` edge, so IDLE never re-accepts the completed request.
- `r_ready_o`, `r_last_o`, `w_ready_o`, `w_last_o` and `r_data_o` are registered outputs.
- SRAM read uses a synchronous port. The read address is presented in the last WAIT cycle, or on the accept edge when LATENCY=0.

## Configuration
- `YSYX_23060077_LSU_RESP_ALIGN_CHECK_EN`
- Defined: adds output `align_err_o` (1 bit), sticky until reset. It sets when an accepted request has half at addr[0]=1, word at addr[1:0]≠0, or size>2. The transaction still completes with truncation.
- Undefined: no port and no check logic.

## Structure
- `ysyx_23060077_define.v` holds the FSM state encodings, size codes, and the data/addr/len/size widths, shared with the LSU.
- Sub-module `ysyx_23060077_sram_1rw`: single port, 32-bit, byte write enables, synchronous read, depth `MEM_WORDS`.

## Test plan
- LATENCY=2. Write word 0xDEADBEEF to 0x8000_0010, then read word from the same address → `w_ready_o&w_last_o` at cycle 3 after accept; read returns 0xDEADBEEF with `r_last_o` at cycle 3.
- Read byte at 0x8000_0013 after the previous write → `r_data_o`=0x0000_00DE. Half at 0x8000_0012 → 0x0000_DEAD.
- Write byte 0x55 to 0x8000_0011, then read word 0x8000_0010 → 0xDEAD55EF.
- Read with len=3 from 0x8000_0000 → four `r_ready_o` pulses, each separated by 2 wait cycles, addresses +4; `r_last_o` only on the 4th.
- `r_valid_i` and `w_valid_i` raised in the same cycle → read completes first; write accepted the cycle after read `last`. Read from 0x0000_0000 → data 0; a write there leaves the SRAM unchanged.
- Reset asserted during RWAIT → next cycle all outputs 0 and `busy_o`=0. With ALIGN_CHECK_EN, a word read at 0x8000_0002 sets `align_err_o`=1, which stays high until reset.

Source files
------------

// File: rtl/ysyx_23060077_lsu_resp_pkg.sv
// Shared encodings for the LSU simple-bus responder: FSM states, size codes,
// bus field widths and lane helper functions.
package ysyx_23060077_lsu_resp_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned LEN_WIDTH  = 8;
    localparam int unsigned SIZE_WIDTH = 3;
    localparam int unsigned LAT_WIDTH  = 4;

    localparam logic [SIZE_WIDTH-1:0] SZ_BYTE = 3'd0;
    localparam logic [SIZE_WIDTH-1:0] SZ_HALF = 3'd1;
    localparam logic [SIZE_WIDTH-1:0] SZ_WORD = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RWAIT = 3'd1,
        S_RBEAT = 3'd2,
        S_WWAIT = 3'd3,
        S_WBEAT = 3'd4
    } state_e;

    // Lanes shifted past byte 3 fall off the top: truncation, never wrap.
    function automatic logic [3:0] byte_en(input logic [SIZE_WIDTH-1:0] size,
                                           input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001;
            SZ_HALF: m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m << off;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rd_format(input logic [DATA_WIDTH-1:0] word,
                                                        input logic [SIZE_WIDTH-1:0] size,
                                                        input logic [1:0] off);
        logic [DATA_WIDTH-1:0] s;
        logic [DATA_WIDTH-1:0] r;
        s = word >> {off, 3'b000};
        case (size)
            SZ_BYTE: r = {24'b0, s[7:0]};
            SZ_HALF: r = {16'b0, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    function automatic logic misaligned(input logic [SIZE_WIDTH-1:0] size,
                                        input logic [1:0] off);
        return (size == SZ_HALF && off[0]) ||
               (size == SZ_WORD && off != 2'b00) ||
               (size > SZ_WORD);
    endfunction

endpackage

// File: rtl/ysyx_23060077_lsu_resp_if.sv
// LSU simple load/store bus. Signal suffixes are from the responder's side.
interface ysyx_23060077_lsu_resp_if;
    import ysyx_23060077_lsu_resp_pkg::*;

    logic                  r_valid_i;
    logic [ADDR_WIDTH-1:0] r_addr_i;
    logic [SIZE_WIDTH-1:0] r_size_i;
    logic [LEN_WIDTH-1:0]  r_len_i;
    logic                  r_ready_o;
    logic [DATA_WIDTH-1:0] r_data_o;
    logic                  r_last_o;
    logic                  w_valid_i;
    logic [ADDR_WIDTH-1:0] w_addr_i;
    logic [DATA_WIDTH-1:0] w_data_i;
    logic [SIZE_WIDTH-1:0] w_size_i;
    logic [LEN_WIDTH-1:0]  w_len_i;
    logic                  w_ready_o;
    logic                  w_last_o;
    logic                  busy_o;

    modport slave (
        input  r_valid_i, r_addr_i, r_size_i, r_len_i,
        input  w_valid_i, w_addr_i, w_data_i, w_size_i, w_len_i,
        output r_ready_o, r_data_o, r_last_o, w_ready_o, w_last_o, busy_o
    );

    modport master (
        output r_valid_i, r_addr_i, r_size_i, r_len_i,
        output w_valid_i, w_addr_i, w_data_i, w_size_i, w_len_i,
        input  r_ready_o, r_data_o, r_last_o, w_ready_o, w_last_o, busy_o
    );

endinterface

// File: rtl/ysyx_23060077_lsu_resp_sram_1rw.sv
// Single-port 32-bit SRAM with byte write enables and synchronous read.
// Contents are never reset.
module ysyx_23060077_sram_1rw #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [MEM_WORDS];
    logic [31:0] rdata_q;

    // Byte-lane write when any enable is set, otherwise read the addressed word.
    always_ff @(posedge clk) begin
        if (|we_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_23060077_lsu_resp.sv
// LSU simple-bus memory responder backed by an internal SRAM with a fixed
// access latency. Optional feature macro: YSYX_23060077_LSU_RESP_ALIGN_CHECK_EN
// adds a sticky align_err_o output.
module ysyx_23060077_lsu_resp
    import ysyx_23060077_lsu_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    ysyx_23060077_lsu_resp_if.slave       bus
`ifdef YSYX_23060077_LSU_RESP_ALIGN_CHECK_EN
    ,
    output logic                          align_err_o
`endif
);

    localparam int unsigned          AW  = $clog2(MEM_WORDS);
    localparam logic [LAT_WIDTH-1:0] LAT = LAT_WIDTH'(LATENCY);

    state_e                 state_q, state_d;
    logic [LAT_WIDTH-1:0]   lat_q, lat_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [SIZE_WIDTH-1:0]  size_q, size_d;
    logic                   r_ready_q, r_last_q, w_ready_q, w_last_q, busy_q;
    logic                   accept;

    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [31:0]            mem_word;
    logic                   mem_oor;
    logic                   beat_oor;
    logic [3:0]             sram_we;
    logic [DATA_WIDTH-1:0]  sram_wdata;
    logic [DATA_WIDTH-1:0]  sram_rdata;

    function automatic logic is_oor(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] off;
        off = a - ADDR_BASE;
        return (a < ADDR_BASE) || ((off >> 2) >= 32'(MEM_WORDS));
    endfunction

    // Next-state and request capture; all fields default to holding.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        len_d   = len_q;
        addr_d  = addr_q;
        size_d  = size_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.r_valid_i) begin
                    accept  = 1'b1;
                    addr_d  = bus.r_addr_i;
                    size_d  = bus.r_size_i;
                    len_d   = bus.r_len_i;
                    lat_d   = LAT;
                    state_d = (LAT == '0) ? S_RBEAT : S_RWAIT;
                end else if (bus.w_valid_i) begin
                    accept  = 1'b1;
                    addr_d  = bus.w_addr_i;
                    size_d  = bus.w_size_i;
                    len_d   = bus.w_len_i;
                    lat_d   = LAT;
                    state_d = (LAT == '0) ? S_WBEAT : S_WWAIT;
                end
            end
            S_RWAIT, S_WWAIT: begin
                // Counter holds the wait cycles left including this one.
                if (lat_q <= 4'd1) begin
                    lat_d   = '0;
                    state_d = (state_q == S_RWAIT) ? S_RBEAT : S_WBEAT;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_RBEAT, S_WBEAT: begin
                if (len_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_q + 32'd4;
                    len_d   = len_q - 8'd1;
                    lat_d   = LAT;
                    if (state_q == S_RBEAT) begin
                        state_d = (LAT == '0) ? S_RBEAT : S_RWAIT;
                    end else begin
                        state_d = (LAT == '0) ? S_WBEAT : S_WWAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, request fields and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            lat_q     <= '0;
            len_q     <= '0;
            addr_q    <= '0;
            size_q    <= '0;
            r_ready_q <= 1'b0;
            r_last_q  <= 1'b0;
            w_ready_q <= 1'b0;
            w_last_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            r_ready_q <= (state_d == S_RBEAT);
            r_last_q  <= (state_d == S_RBEAT) && (len_d == '0);
            w_ready_q <= (state_d == S_WBEAT);
            w_last_q  <= (state_d == S_WBEAT) && (len_d == '0);
            busy_q    <= (state_d != S_IDLE);
        end
    end

    // SRAM address: the read issued one cycle ahead of each read beat lands
    // in the SRAM output register exactly when that beat is presented.
    always_comb begin
        mem_addr = addr_q;
        case (state_q)
            S_IDLE:  mem_addr = bus.r_addr_i;
            S_RBEAT: mem_addr = addr_q + 32'd4;
            default: mem_addr = addr_q;
        endcase
    end

    assign mem_word   = (mem_addr - ADDR_BASE) >> 2;
    assign mem_oor    = (mem_addr < ADDR_BASE) || (mem_word >= 32'(MEM_WORDS));
    assign beat_oor   = is_oor(addr_q);
    assign sram_we    = (state_q == S_WBEAT && !mem_oor && !reset)
                        ? byte_en(size_q, addr_q[1:0]) : '0;
    assign sram_wdata = bus.w_data_i << {addr_q[1:0], 3'b000};

    ysyx_23060077_sram_1rw #(
        .MEM_WORDS (MEM_WORDS)
    ) u_sram (
        .clk     (clk),
        .we_i    (sram_we),
        .addr_i  (mem_word[AW-1:0]),
        .wdata_i (sram_wdata),
        .rdata_o (sram_rdata)
    );

    assign bus.r_ready_o = r_ready_q;
    assign bus.r_last_o  = r_last_q;
    assign bus.r_data_o  = (r_ready_q && !beat_oor)
                           ? rd_format(sram_rdata, size_q, addr_q[1:0]) : '0;
    assign bus.w_ready_o = w_ready_q;
    assign bus.w_last_o  = w_last_q;
    assign bus.busy_o    = busy_q;

`ifdef YSYX_23060077_LSU_RESP_ALIGN_CHECK_EN
    logic align_err_q;

    // Sticky misalignment flag, sampled on request accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            align_err_q <= 1'b0;
        end else if (accept && misaligned(size_d, addr_d[1:0])) begin
            align_err_q <= 1'b1;
        end
    end

    assign align_err_o = align_err_q;
`endif

endmodule

// File: tb/tb_ysyx_23060077_lsu_resp.sv
// Directed self-checking bench for ysyx_23060077_lsu_resp (LATENCY=2).
module tb_ysyx_23060077_lsu_resp;

    logic clk = 1'b0;
    logic reset;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [31:0] beat_data [4];
`ifdef YSYX_23060077_LSU_RESP_ALIGN_CHECK_EN
    logic align_err;
`endif

    always #5 clk = ~clk;

    ysyx_23060077_lsu_resp_if bus ();

    ysyx_23060077_lsu_resp #(
        .MEM_WORDS (1024),
        .ADDR_BASE (32'h8000_0000),
        .LATENCY   (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef YSYX_23060077_LSU_RESP_ALIGN_CHECK_EN
        ,
        .align_err_o (align_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction; beat_data holds write data or expected read data.
    // Every beat must arrive 3 cycles after the previous beat (or after accept).
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [7:0] len, input string tag);
        int  cyc;
        bit  seen;
        @(negedge clk);
        if (wr) begin
            bus.w_valid_i = 1'b1; bus.w_addr_i = addr;
            bus.w_size_i  = size; bus.w_len_i  = len;
        end else begin
            bus.r_valid_i = 1'b1; bus.r_addr_i = addr;
            bus.r_size_i  = size; bus.r_len_i  = len;
        end
        for (int b = 0; b <= int'(len); b++) begin
            if (b > 0) begin
                @(posedge clk);
                #1;
            end
            if (wr) bus.w_data_i = beat_data[b];
            cyc  = 0;
            seen = 1'b0;
            while (!seen && cyc < 40) begin
                @(negedge clk);
                cyc++;
                seen = wr ? bus.w_ready_o : bus.r_ready_o;
            end
            check({tag, " beat latency"}, 32'(cyc), 32'd3);
            if (wr) begin
                check({tag, " w_last"}, {31'b0, bus.w_last_o}, {31'b0, (b == int'(len))});
            end else begin
                check({tag, " r_data"}, bus.r_data_o, beat_data[b]);
                check({tag, " r_last"}, {31'b0, bus.r_last_o}, {31'b0, (b == int'(len))});
            end
        end
        bus.r_valid_i = 1'b0;
        bus.w_valid_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  seen;
        bus.r_valid_i = 1'b0; bus.r_addr_i = '0; bus.r_size_i = '0; bus.r_len_i = '0;
        bus.w_valid_i = 1'b0; bus.w_addr_i = '0; bus.w_data_i = '0;
        bus.w_size_i  = '0;   bus.w_len_i  = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        check("reset r_ready", {31'b0, bus.r_ready_o}, 32'd0);
        check("reset r_last",  {31'b0, bus.r_last_o},  32'd0);
        check("reset r_data",  bus.r_data_o,           32'd0);
        check("reset w_ready", {31'b0, bus.w_ready_o}, 32'd0);
        check("reset w_last",  {31'b0, bus.w_last_o},  32'd0);
        check("reset busy",    {31'b0, bus.busy_o},    32'd0);
`ifdef YSYX_23060077_LSU_RESP_ALIGN_CHECK_EN
        check("reset align_err", {31'b0, align_err}, 32'd0);
`endif
        reset = 1'b0;

        beat_data[0] = 32'hDEAD_BEEF; xfer(1, 32'h8000_0010, 3'd2, 8'd0, "wr word 0x10");
        beat_data[0] = 32'hDEAD_BEEF; xfer(0, 32'h8000_0010, 3'd2, 8'd0, "rd word 0x10");
        beat_data[0] = 32'h0000_00DE; xfer(0, 32'h8000_0013, 3'd0, 8'd0, "rd byte 0x13");
        beat_data[0] = 32'h0000_DEAD; xfer(0, 32'h8000_0012, 3'd1, 8'd0, "rd half 0x12");

        beat_data[0] = 32'h0000_0055; xfer(1, 32'h8000_0011, 3'd0, 8'd0, "wr byte 0x11");
        beat_data[0] = 32'hDEAD_55EF; xfer(0, 32'h8000_0010, 3'd2, 8'd0, "rd word after byte wr");

        // Half at offset 3: only lane 3 is reachable.
        beat_data[0] = 32'h0000_00DE; xfer(0, 32'h8000_0013, 3'd1, 8'd0, "rd half 0x13 trunc");
        beat_data[0] = 32'h0000_A1B2; xfer(1, 32'h8000_0013, 3'd1, 8'd0, "wr half 0x13 trunc");
        beat_data[0] = 32'hB2AD_55EF; xfer(0, 32'h8000_0010, 3'd2, 8'd0, "rd word after half wr");

        beat_data[0] = 32'h1111_1111; beat_data[1] = 32'h2222_2222;
        beat_data[2] = 32'h3333_3333; beat_data[3] = 32'h4444_4444;
        xfer(1, 32'h8000_0000, 3'd2, 8'd3, "wr burst4");
        xfer(0, 32'h8000_0000, 3'd2, 8'd3, "rd burst4");

        // Simultaneous read and write: read first, write right after read last.
        @(negedge clk);
        bus.r_valid_i = 1'b1; bus.r_addr_i = 32'h8000_0004; bus.r_size_i = 3'd2; bus.r_len_i = 8'd0;
        bus.w_valid_i = 1'b1; bus.w_addr_i = 32'h8000_0008; bus.w_size_i = 3'd2; bus.w_len_i = 8'd0;
        bus.w_data_i  = 32'hCAFE_F00D;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk); cyc++;
            seen = bus.r_ready_o;
            if (bus.w_ready_o) check("both valid: write before read", 32'd1, 32'd0);
        end
        check("both valid rd latency", 32'(cyc), 32'd3);
        check("both valid rd data", bus.r_data_o, 32'h2222_2222);
        check("both valid rd last", {31'b0, bus.r_last_o}, 32'd1);
        bus.r_valid_i = 1'b0;
        @(negedge clk);
        check("idle between rd and wr busy", {31'b0, bus.busy_o}, 32'd0);
        cyc = 1; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk); cyc++;
            seen = bus.w_ready_o;
        end
        check("pending wr latency after rd last", 32'(cyc), 32'd4);
        check("pending wr last", {31'b0, bus.w_last_o}, 32'd1);
        bus.w_valid_i = 1'b0;
        beat_data[0] = 32'hCAFE_F00D; xfer(0, 32'h8000_0008, 3'd2, 8'd0, "rd pending wr word");

        // Out-of-range accesses complete but never touch the SRAM.
        beat_data[0] = 32'h0000_0000; xfer(0, 32'h0000_0000, 3'd2, 8'd0, "oor rd low");
        beat_data[0] = 32'h0000_0000; xfer(0, 32'h7FFF_FFFC, 3'd2, 8'd0, "oor rd below base");
        beat_data[0] = 32'h1234_5678; xfer(1, 32'h0000_0000, 3'd2, 8'd0, "oor wr low");
        beat_data[0] = 32'hABCD_ABCD; xfer(1, 32'h8000_1000, 3'd2, 8'd0, "oor wr high");
        beat_data[0] = 32'h0000_0000; xfer(0, 32'h8000_1000, 3'd2, 8'd0, "oor rd high");
        beat_data[0] = 32'h1111_1111; xfer(0, 32'h8000_0000, 3'd2, 8'd0, "word0 after oor wr");
        beat_data[0] = 32'h5A5A_0001; xfer(1, 32'h8000_0FFC, 3'd2, 8'd0, "wr last word");
        beat_data[0] = 32'h5A5A_0001; xfer(0, 32'h8000_0FFC, 3'd2, 8'd0, "rd last word");

        // Reset while waiting: no handshake afterwards.
        @(negedge clk);
        bus.r_valid_i = 1'b1; bus.r_addr_i = 32'h8000_0010; bus.r_size_i = 3'd2; bus.r_len_i = 8'd0;
        @(negedge clk);
        check("busy in rwait", {31'b0, bus.busy_o}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.r_valid_i = 1'b0;
        check("abort r_ready", {31'b0, bus.r_ready_o}, 32'd0);
        check("abort r_last",  {31'b0, bus.r_last_o},  32'd0);
        check("abort r_data",  bus.r_data_o,           32'd0);
        check("abort busy",    {31'b0, bus.busy_o},    32'd0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | bus.r_ready_o | bus.r_last_o | bus.busy_o;
        end
        check("no handshake after abort", {31'b0, seen}, 32'd0);

`ifdef YSYX_23060077_LSU_RESP_ALIGN_CHECK_EN
        check("align_err clear", {31'b0, align_err}, 32'd0);
        beat_data[0] = 32'h0000_1111; xfer(0, 32'h8000_0002, 3'd2, 8'd0, "misaligned word rd");
        check("align_err set", {31'b0, align_err}, 32'd1);
        beat_data[0] = 32'h1111_1111; xfer(0, 32'h8000_0000, 3'd2, 8'd0, "aligned rd after err");
        check("align_err sticky", {31'b0, align_err}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("align_err cleared by reset", {31'b0, align_err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
